// File: rtl/string_led_decoder.sv
// string_led_decoder: decodes WS2812-style pulses on din into 24-bit GRB words with LED index and latch (frame end) detection.
// Latency: din fall to word_valid 3 clk; din low start to frame_end RESET_CYCLES+2 clk. Backpressure: one-word slot, a word arriving while it is full is dropped (err_overflow).
// Optional: define STRING_LED_DECODER_GLITCH_FILTER_EN to ignore high pulses shorter than MIN_HIGH instead of flagging them.
module string_led_decoder #(
    parameter int BIT_THRESHOLD = 24,
    parameter int MIN_HIGH      = 4,
    parameter int MAX_HIGH      = 48,
    parameter int RESET_CYCLES  = 2000,
    parameter int CNT_W         = 16,
    parameter int INDEX_W       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               din,
    output logic [23:0]        word_data,
    output logic [INDEX_W-1:0] word_index,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               frame_end,
    output logic [INDEX_W-1:0] frame_leds,
    output logic               err_timing,
    output logic               err_partial,
    output logic               err_overflow,
    input  logic               err_clear
);
    localparam logic [CNT_W-1:0]   HIGH_SAT = CNT_W'(MAX_HIGH + 1);
    localparam logic [CNT_W-1:0]   LOW_SAT  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0]   MIN_H    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0]   MAX_H    = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0]   THR      = CNT_W'(BIT_THRESHOLD);
    localparam logic [INDEX_W-1:0] LED_MAX  = '1;

    logic               din_meta_q, din_s_q, din_s_dly_q;
    logic [CNT_W-1:0]   high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
    logic [23:0]        shreg_q, shreg_d, word_data_q, word_data_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [INDEX_W-1:0] led_cnt_q, led_cnt_d, word_index_q, word_index_d;
    logic [INDEX_W-1:0] frame_leds_q, frame_leds_d;
    logic               seen_q, seen_d, word_valid_q, word_valid_d, frame_end_q, frame_end_d;
    logic               err_timing_q, err_timing_d, err_partial_q, err_partial_d;
    logic               err_overflow_q, err_overflow_d;
    logic               fall, pulse_short, pulse_long, pulse_ok, pulse_bad, pulse_drop;
    logic               set_timing, set_partial, set_overflow;

    assign fall        = din_s_dly_q & ~din_s_q;
    assign pulse_short = high_cnt_q < MIN_H;
    assign pulse_long  = high_cnt_q > MAX_H;
    assign pulse_ok    = fall & ~pulse_short & ~pulse_long;
`ifdef STRING_LED_DECODER_GLITCH_FILTER_EN
    assign pulse_drop  = fall & pulse_short;
    assign pulse_bad   = fall & pulse_long;
`else
    assign pulse_drop  = 1'b0;
    assign pulse_bad   = fall & (pulse_short | pulse_long);
`endif

    always_comb begin
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        led_cnt_d    = led_cnt_q;
        seen_d       = seen_q;
        word_data_d  = word_data_q;
        word_index_d = word_index_q;
        word_valid_d = word_valid_q;
        frame_leds_d = frame_leds_q;
        frame_end_d  = 1'b0;
        set_timing   = 1'b0;
        set_partial  = 1'b0;
        set_overflow = 1'b0;

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (!enable) begin
            high_cnt_d = '0;
            low_cnt_d  = '0;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            led_cnt_d  = '0;
            seen_d     = 1'b0;
        end else begin
            if (din_s_q) begin
                high_cnt_d = (high_cnt_q == HIGH_SAT) ? HIGH_SAT : high_cnt_q + 1'b1;
`ifdef STRING_LED_DECODER_GLITCH_FILTER_EN
                // Hold the low count so a filtered glitch does not delay latch detection
                low_cnt_d  = low_cnt_q;
`else
                low_cnt_d  = '0;
`endif
            end else begin
                high_cnt_d = '0;
                if (fall && !pulse_drop) begin
                    low_cnt_d = CNT_W'(1);
                end else begin
                    low_cnt_d = (low_cnt_q == LOW_SAT) ? LOW_SAT : low_cnt_q + 1'b1;
                end
            end

            if (pulse_bad) begin
                set_timing = 1'b1;
                shreg_d    = '0;
                bit_cnt_d  = '0;
            end else if (pulse_ok) begin
                seen_d  = 1'b1;
                shreg_d = {shreg_q[22:0], high_cnt_q >= THR};
                if (bit_cnt_q == 5'd23) begin
                    bit_cnt_d = '0;
                    if (!word_valid_q || word_ready) begin
                        word_data_d  = {shreg_q[22:0], high_cnt_q >= THR};
                        word_index_d = led_cnt_q;
                        word_valid_d = 1'b1;
                    end else begin
                        set_overflow = 1'b1;
                    end
                    if (led_cnt_q != LED_MAX) begin
                        led_cnt_d = led_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end

            if (seen_q && low_cnt_q != LOW_SAT && low_cnt_d == LOW_SAT) begin
                frame_end_d  = 1'b1;
                frame_leds_d = led_cnt_q;
                led_cnt_d    = '0;
                seen_d       = 1'b0;
                if (bit_cnt_q != 5'd0) begin
                    set_partial = 1'b1;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                end
            end
        end

        err_timing_d   = err_clear ? 1'b0 : (err_timing_q | set_timing);
        err_partial_d  = err_clear ? 1'b0 : (err_partial_q | set_partial);
        err_overflow_d = err_clear ? 1'b0 : (err_overflow_q | set_overflow);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_meta_q     <= 1'b0;
            din_s_q        <= 1'b0;
            din_s_dly_q    <= 1'b0;
            high_cnt_q     <= '0;
            low_cnt_q      <= '0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            led_cnt_q      <= '0;
            seen_q         <= 1'b0;
            word_data_q    <= '0;
            word_index_q   <= '0;
            word_valid_q   <= 1'b0;
            frame_leds_q   <= '0;
            frame_end_q    <= 1'b0;
            err_timing_q   <= 1'b0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            din_meta_q     <= din;
            din_s_q        <= din_meta_q;
            din_s_dly_q    <= din_s_q;
            high_cnt_q     <= high_cnt_d;
            low_cnt_q      <= low_cnt_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            led_cnt_q      <= led_cnt_d;
            seen_q         <= seen_d;
            word_data_q    <= word_data_d;
            word_index_q   <= word_index_d;
            word_valid_q   <= word_valid_d;
            frame_leds_q   <= frame_leds_d;
            frame_end_q    <= frame_end_d;
            err_timing_q   <= err_timing_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign word_data    = word_data_q;
    assign word_index   = word_index_q;
    assign word_valid   = word_valid_q;
    assign frame_end    = frame_end_q;
    assign frame_leds   = frame_leds_q;
    assign err_timing   = err_timing_q;
    assign err_partial  = err_partial_q;
    assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_string_led_decoder.sv
// tb_string_led_decoder: drives pulse trains on din and compares decoded words, frame ends and flags
// against a pulse-level reference model of the decoding rules.
module tb_string_led_decoder;
    localparam int TH   = 24;
    localparam int MINH = 4;
    localparam int MAXH = 48;
    localparam int R    = 2000;
    localparam int IW   = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          din = 1'b0;
    logic          word_ready = 1'b1;
    logic          err_clear = 1'b0;
    logic [23:0]   word_data;
    logic [IW-1:0] word_index;
    logic          word_valid;
    logic          frame_end;
    logic [IW-1:0] frame_leds;
    logic          err_timing, err_partial, err_overflow;

    string_led_decoder #(
        .BIT_THRESHOLD(TH), .MIN_HIGH(MINH), .MAX_HIGH(MAXH),
        .RESET_CYCLES(R), .CNT_W(16), .INDEX_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din),
        .word_data(word_data), .word_index(word_index), .word_valid(word_valid),
        .word_ready(word_ready), .frame_end(frame_end), .frame_leds(frame_leds),
        .err_timing(err_timing), .err_partial(err_partial), .err_overflow(err_overflow),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Observed traffic
    logic [23:0] got_dat[$];
    int          got_idx[$];
    int          got_cyc[$];
    int          got_fe[$];
    int          got_fe_cyc[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (word_valid && word_ready) begin
                got_dat.push_back(word_data);
                got_idx.push_back(int'(word_index));
                got_cyc.push_back(cyc);
            end
            if (frame_end) begin
                got_fe.push_back(int'(frame_leds));
                got_fe_cyc.push_back(cyc);
            end
        end
    end

    // Reference model: operates on whole pulses (high width, following low gap)
    logic [23:0] m_sh;
    int          m_nb, m_led, m_low;
    bit          m_seen, m_slot, m_et, m_ep, m_eo;
    logic [23:0] e_dat[$];
    int          e_idx[$];
    int          e_cyc[$];
    int          e_fe[$];
    int          e_fe_cyc[$];

    task automatic m_reset();
        m_sh = '0; m_nb = 0; m_led = 0; m_low = 0;
        m_seen = 0; m_slot = 0; m_et = 0; m_ep = 0; m_eo = 0;
    endtask

    task automatic m_pulse(input int h, input int l, input int f);
        bit ign;
        ign = 0;
        if (h > MAXH) begin
            m_et = 1; m_nb = 0; m_sh = '0;
        end else if (h < MINH) begin
`ifdef STRING_LED_DECODER_GLITCH_FILTER_EN
            ign = 1;
`else
            m_et = 1; m_nb = 0; m_sh = '0;
`endif
        end else begin
            m_sh = {m_sh[22:0], (h >= TH)};
            m_nb++;
            m_seen = 1;
            if (m_nb == 24) begin
                if (word_ready || !m_slot) begin
                    e_dat.push_back(m_sh);
                    e_idx.push_back(m_led);
                    e_cyc.push_back(f + 3);
                    m_slot = !word_ready;
                end else begin
                    m_eo = 1;
                end
                if (m_led < (1 << IW) - 1) m_led++;
                m_nb = 0;
            end
        end
        if (!ign) m_low = 0;
        if (m_seen && m_low < R && m_low + l >= R) begin
            e_fe.push_back(m_led);
            e_fe_cyc.push_back(f + 2 + R - m_low);
            m_led = 0;
            if (m_nb != 0) begin
                m_ep = 1; m_nb = 0;
            end
            m_seen = 0;
        end
        m_low = (m_low + l >= R) ? R : m_low + l;
    endtask

    // Pulse list to drive
    int p_h[$];
    int p_l[$];

    task automatic add_bit(input bit b, input int gap);
        p_h.push_back(b ? 32 : 16);
        p_l.push_back(gap);
    endtask

    task automatic add_word(input logic [23:0] w, input int gap_last);
        for (int i = 23; i >= 0; i--) begin
            add_bit(w[i], (i == 0) ? gap_last : (w[i] ? 18 : 34));
        end
    endtask

    task automatic run_pulses();
        int h, l, f;
        while (p_h.size() > 0) begin
            h = p_h.pop_front();
            l = p_l.pop_front();
            din = 1'b1;
            tick(h);
            din = 1'b0;
            f = cyc;
            m_pulse(h, l, f);
            tick(l);
        end
    endtask

    task automatic start_scn();
        got_dat.delete(); got_idx.delete(); got_cyc.delete(); got_fe.delete(); got_fe_cyc.delete();
        e_dat.delete(); e_idx.delete(); e_cyc.delete(); e_fe.delete(); e_fe_cyc.delete();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        m_et = 0; m_ep = 0; m_eo = 0;
    endtask

    task automatic end_scn(input string nm, input bit do_cyc);
        check({nm, " words"}, got_dat.size(), e_dat.size());
        for (int i = 0; i < e_dat.size() && i < got_dat.size(); i++) begin
            check({nm, " data"}, got_dat[i], e_dat[i]);
            check({nm, " index"}, got_idx[i], e_idx[i]);
            if (do_cyc) check({nm, " valid_cycle"}, got_cyc[i], e_cyc[i]);
        end
        check({nm, " frames"}, got_fe.size(), e_fe.size());
        for (int i = 0; i < e_fe.size() && i < got_fe.size(); i++) begin
            check({nm, " frame_leds"}, got_fe[i], e_fe[i]);
            check({nm, " frame_cycle"}, got_fe_cyc[i], e_fe_cyc[i]);
        end
        if (e_fe.size() > 0) check({nm, " frame_leds_held"}, frame_leds, e_fe[e_fe.size()-1]);
        check({nm, " err_timing"}, err_timing, m_et);
        check({nm, " err_partial"}, err_partial, m_ep);
        check({nm, " err_overflow"}, err_overflow, m_eo);
    endtask

    function automatic logic [63:0] all_outs();
        return {15'd0, word_data, word_index, word_valid, frame_end, frame_leds,
                err_timing, err_partial, err_overflow};
    endfunction

    initial begin
        m_reset();
        tick(2);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick(5);

        // Three words, consumer always ready
        start_scn();
        add_word(24'h00FF00, 34); add_word(24'hA5C3E1, 34); add_word(24'hFFFFFF, 2100);
        run_pulses();
        end_scn("three_words", 1);

        // Same stream, consumer stalled: first word held, the rest dropped
        start_scn();
        word_ready = 1'b0;
        add_word(24'h00FF00, 34); add_word(24'hA5C3E1, 34); add_word(24'hFFFFFF, 2100);
        run_pulses();
        check("stall_valid_held", word_valid, 1'b1);
        check("stall_data_held", word_data, 24'h00FF00);
        check("stall_index_held", word_index, 0);
        word_ready = 1'b1;
        m_slot = 0;
        tick(2);
        check("stall_valid_drops", word_valid, 1'b0);
        end_scn("stall", 0);

        // Partial word at latch
        start_scn();
        for (int i = 0; i < 10; i++) add_bit(i[0], (i == 9) ? 2100 : 30);
        run_pulses();
        end_scn("partial", 1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("err_clear", {err_timing, err_partial, err_overflow}, 3'b000);

        // Over-long pulse aborts the word in progress
        start_scn();
        for (int i = 0; i < 5; i++) add_bit(1'b1, 20);
        p_h.push_back(60); p_l.push_back(20);
        add_word(24'h123456, 2100);
        run_pulses();
        end_scn("long_pulse", 1);

        // Width boundaries: MIN, TH-1, TH, MAX -> bits 0,0,1,1
        start_scn();
        for (int i = 0; i < 24; i++) begin
            p_h.push_back((i % 4 == 0) ? MINH : (i % 4 == 1) ? TH - 1 : (i % 4 == 2) ? TH : MAXH);
            p_l.push_back((i == 23) ? 2100 : 20);
        end
        run_pulses();
        end_scn("boundaries", 1);

        // Short glitch inside a low gap
        start_scn();
        add_word(24'h5A5A5A, 2100);
        p_l[11] = 10;
        p_h.insert(12, 2);
        p_l.insert(12, 10);
        run_pulses();
        end_scn("glitch", 1);

        // Reset mid-word clears everything, including sticky flags
        start_scn();
        p_h.push_back(60); p_l.push_back(20);
        for (int i = 0; i < 12; i++) add_bit(i[1], 20);
        run_pulses();
        check("pre_reset_err_timing", err_timing, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("mid_reset_outputs", all_outs(), 64'd0);
        tick(2);
        rst_n = 1'b1;
        m_reset();
        tick(3);
        start_scn();
        add_word(24'hC0FFEE, 2100);
        run_pulses();
        end_scn("after_reset", 1);

        // Disable drops the partial word and LED position
        start_scn();
        for (int i = 0; i < 5; i++) add_bit(1'b1, 10);
        run_pulses();
        enable = 1'b0;
        tick(10);
        m_nb = 0; m_sh = '0; m_led = 0; m_low = 0; m_seen = 0;
        enable = 1'b1;
        tick(5);
        add_word(24'h0F0F0F, 2100);
        run_pulses();
        end_scn("enable", 1);

        // Random pulse trains including illegal widths
        for (int s = 0; s < 4; s++) begin
            int n, r;
            start_scn();
            n = $urandom_range(40, 70);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 19);
                if (r < 10)       p_h.push_back($urandom_range(MINH, MAXH));
                else if (r < 18)  p_h.push_back((r % 2 == 0) ? 16 : 32);
                else if (r == 18) p_h.push_back($urandom_range(1, MINH - 1));
                else              p_h.push_back($urandom_range(MAXH + 1, MAXH + 12));
                p_l.push_back((i == n - 1) ? 2100 : $urandom_range(1, 40));
            end
            run_pulses();
            end_scn("random", 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
